mips16_trace_buffer: RTL
========================

Name: mips16_trace_buffer

Overview:
- Trigger-based capture buffer that sits directly downstream of the MIPS16 core and consumes its pc_out and alu_result every clock.
- Keeps a circular pre-trigger history. On a PC match it captures a fixed post-trigger window, then freezes.
- The frozen contents are read out oldest-first through a simple request/valid port.
- Gives the bench and board debug logic a cycle-accurate execution trace without $monitor.

Parameters:
- DEPTH, 16: number of entries; power of two, ≥4.
- ADDR_W, 4: log2(DEPTH).
- POST_SAMPLES, 4: samples captured after the trigger sample; 0 ≤ POST_SAMPLES < DEPTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- arm  input  1  one-cycle pulse; clears the buffer, latches trig_pc, starts capture.
- trig_pc  input  16  PC trigger value; sampled only on the arm cycle.
- cap_en  input  1  core running qualifier; no write occurs when low.
- pc_in  input  16  from core pc_out.
- alu_in  input  16  from core alu_result.
- rd_req  input  1  read request; accepted only in DONE.
- rd_data  output  32  {pc, alu} of the entry read.
- rd_valid  output  1  one-cycle strobe qualifying rd_data.
- rd_ts  output  16  entry timestamp (see Optional Feature).
- done  output  1  high in DONE.
- state_out  output  2  IDLE=0, ARMED=1, POST=2, DONE=3.
- count  output  ADDR_W+1  valid entries held, saturates at DEPTH.

Behaviour:
- Reset (asynchronous, any state, including mid-capture or mid-read):
  - state IDLE.
  - wr_ptr, rd_ptr, count, post_cnt, remaining reset to 0.
  - rd_data, rd_ts, rd_valid, done reset to 0.
  - Buffer RAM contents are don't-care.
- IDLE: no writes. arm → ARMED, latch trig_pc, clear wr_ptr and count.
- ARMED, on each cycle with cap_en=1:
  - Write {pc_in, alu_in} at wr_ptr; wr_ptr increments mod DEPTH.
  - count increments, saturating at DEPTH.
  - If pc_in == latched trig_pc, that sample is written. Then → POST with post_cnt = POST_SAMPLES, or → DONE directly if POST_SAMPLES = 0.
- POST, on each cycle with cap_en=1:
  - Write as in ARMED and decrement post_cnt.
  - The write that takes post_cnt to 0 is the last one; next state is DONE.
  - Further PC matches are ignored.
  - cap_en=0 holds all pointers and counters.
- Entry into DONE:
  - rd_ptr = wr_ptr if count == DEPTH, else 0 (oldest entry).
  - remaining = count.
  - done = 1.
- DONE, read port:
  - rd_req with remaining > 0: rd_data and rd_ts are registered and rd_valid = 1 on the following cycle (1-cycle latency). rd_ptr increments mod DEPTH; remaining decrements.
  - rd_req with remaining = 0: ignored, rd_valid stays 0.
  - rd_valid is 0 on any cycle not following an accepted request.
  - rd_data holds its last value.
- arm in any state restarts capture: clear, → ARMED.
- arm and rd_req in the same cycle: arm wins, and the read is not accepted.
- The trigger compare is 16-bit equality, unqualified by alu_in.
- The buffer is single-port: a write occurs only in ARMED/POST and a read only in DONE, never both.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - A 16-bit cycle counter clears on arm and increments every clock in ARMED/POST (wraps 0xFFFF → 0x0000), regardless of cap_en.
  - Its value is stored with each entry and returned on rd_ts alongside rd_data.
- Undefined:
  - No counter and no timestamp storage.
  - rd_ts is tied to 0.
  - All other behaviour is identical.

Test Plan:
1. Reset behaviour:
   - Stimulus: assert reset for 5 cycles, then mid-run assert reset asynchronously between clock edges.
   - Required: state_out=0, done=0, count=0, rd_valid=0, rd_data=0 immediately and while held.
2. Basic trigger (DEPTH=16, POST_SAMPLES=4):
   - Stimulus: arm with trig_pc=0x0008, cap_en=1, pc_in=0,2,4,… each cycle, alu_in=pc+1.
   - Required: trigger on the 5th sample; done after pc 0x0010; count=9.
   - Required: 9 reads return {0x0000,0x0001} … {0x0010,0x0011}, each with rd_valid one cycle after rd_req.
3. Wrap-around:
   - Stimulus: trig_pc=0x0040, pc_in=2·i.
   - Required: 37 samples written; count=16; readout runs 0x002A … 0x0048 in order.
4. cap_en gating:
   - Stimulus: in POST, drop cap_en for 3 cycles.
   - Required: count, post_cnt and wr_ptr are held; done asserts only after 4 qualified samples total.
5. Read boundary:
   - Stimulus: after 16 accepted reads, issue a 17th rd_req.
   - Required: rd_valid=0.
   - Stimulus: arm and rd_req in the same cycle.
   - Required: no rd_valid, state_out=1, count=0.
6. Timestamp (TRACE_TIMESTAMP_EN defined):
   - Stimulus: rerun scenario 2 with cap_en low on cycle 2.
   - Required: rd_ts values increase by 1 per cycle with a gap of 2 at the stall.
   - Required: with the macro undefined, rd_ts=0 throughout.

Source files
------------

// File: rtl/mips16_trace_buffer.sv
// Trigger-based capture buffer for the MIPS16 core: circular pre-trigger history of {pc, alu},
// a fixed post-trigger window, then an oldest-first readout. Define TRACE_TIMESTAMP_EN for per-entry timestamps.
module mips16_trace_buffer #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int POST_SAMPLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic [15:0]       trig_pc,
  input  logic              cap_en,
  input  logic [15:0]       pc_in,
  input  logic [15:0]       alu_in,
  input  logic              rd_req,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic [15:0]       rd_ts,
  output logic              done,
  output logic [1:0]        state_out,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   FULL      = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(POST_SAMPLES);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(1);
  localparam bit                NO_POST   = (POST_SAMPLES == 0);

  state_t            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] post_cnt_q;
  logic [ADDR_W:0]   remaining_q;
  logic [15:0]       trig_q;
  logic [31:0]       rd_data_q;
  logic              rd_valid_q;
  logic              done_q;

  logic              capturing;
  logic              wr_en;
  logic              hit;
  logic              enter_done;
  logic              rd_ok;
  logic [ADDR_W-1:0] wr_ptr_d;
  logic [ADDR_W:0]   count_d;

  logic [31:0]       mem_q [DEPTH];

  always_comb begin
    capturing  = (state_q == S_ARMED) || (state_q == S_POST);
    wr_en      = !arm && capturing && cap_en;
    wr_ptr_d   = wr_ptr_q + 1'b1;
    count_d    = (count_q == FULL) ? count_q : count_q + 1'b1;
    hit        = (state_q == S_ARMED) && (pc_in == trig_q);
    // The sample that completes the capture is always written before the freeze.
    enter_done = wr_en && ((hit && NO_POST) ||
                           ((state_q == S_POST) && (post_cnt_q == POST_LAST)));
    rd_ok      = !arm && (state_q == S_DONE) && rd_req && (remaining_q != '0);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {pc_in, alu_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      post_cnt_q  <= '0;
      remaining_q <= '0;
      trig_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (arm) begin
        state_q     <= S_ARMED;
        trig_q      <= trig_pc;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        count_q     <= '0;
        post_cnt_q  <= '0;
        remaining_q <= '0;
        done_q      <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
          end
          S_ARMED: begin
            if (wr_en) begin
              wr_ptr_q <= wr_ptr_d;
              count_q  <= count_d;
              if (hit && !NO_POST) begin
                state_q    <= S_POST;
                post_cnt_q <= POST_INIT;
              end
            end
          end
          S_POST: begin
            if (wr_en) begin
              wr_ptr_q   <= wr_ptr_d;
              count_q    <= count_d;
              post_cnt_q <= post_cnt_q - 1'b1;
            end
          end
          S_DONE: begin
            if (rd_ok) begin
              rd_data_q   <= mem_q[rd_ptr_q];
              rd_valid_q  <= 1'b1;
              rd_ptr_q    <= rd_ptr_q + 1'b1;
              remaining_q <= remaining_q - 1'b1;
            end
          end
        endcase
        // A full buffer has its oldest entry at the next write slot; otherwise it starts at 0.
        if (enter_done) begin
          state_q     <= S_DONE;
          done_q      <= 1'b1;
          rd_ptr_q    <= (count_d == FULL) ? wr_ptr_d : '0;
          remaining_q <= count_d;
        end
      end
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] rd_ts_q;
  logic [15:0] ts_mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ts_mem_q[wr_ptr_q] <= ts_q;
    end
  end

  // Counts every capture-phase clock, so cap_en stalls show up as gaps between entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q    <= '0;
      rd_ts_q <= '0;
    end else begin
      if (arm) begin
        ts_q <= '0;
      end else if (capturing) begin
        ts_q <= ts_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ts_q <= ts_mem_q[rd_ptr_q];
      end
    end
  end

  assign rd_ts = rd_ts_q;
`else
  assign rd_ts = 16'h0000;
`endif

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign state_out = state_q;
  assign count     = count_q;

endmodule
